// File: rtl/debug_tx_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : debug_tx_fifo_pkg                                                |
// | Brief   : Shared constants and read-FSM state encoding for debug TX path.  |
// |           State width depends on DEBUG_TX_CRLF_EN.                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package debug_tx_fifo_pkg;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam int         DEBUG_MSG_LEN = 32;

`ifdef DEBUG_TX_CRLF_EN
    localparam int STATE_W = 2;
`else
    localparam int STATE_W = 1;
`endif

    localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_GAP  = STATE_W'(1);
`ifdef DEBUG_TX_CRLF_EN
    localparam logic [STATE_W-1:0] S_LF   = STATE_W'(2);
`endif

endpackage
`default_nettype wire

// File: rtl/debug_tx_fifo_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : byte_fifo                                                        |
// | Brief   : Power-of-two byte FIFO with level count; read data is the        |
// |           combinational head entry.                                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module byte_fifo #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [7:0]           i_wr_data,
    output logic [7:0]           o_rd_data,
    output logic [ADDR_BITS:0]   o_level,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam logic [ADDR_BITS:0] c_depth = (ADDR_BITS+1)'(DEPTH);

    logic [7:0]           r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_level;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Full rejects a push even when a pop frees a slot in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = (r_level == c_depth);
    assign o_empty   = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/debug_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : debug_tx_fifo                                                    |
// | Brief   : Debug message byte FIFO paced out to the AVR serial TX port.     |
// |           Define DEBUG_TX_CRLF_EN to append LF after every CR sent.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module debug_tx_fifo
    import debug_tx_fifo_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_full,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow
);

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [7:0]         w_head;
    logic               r_overflow;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
`ifdef DEBUG_TX_CRLF_EN
    logic               r_lf_pending;
    logic               w_lf_set;
    logic               w_lf_clr;
`endif

    byte_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (in_valid),
        .i_pop     (w_pop),
        .i_wr_data (in_data),
        .o_rd_data (w_head),
        .o_level   (level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign in_full  = w_full;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (rst)                      r_overflow <= 1'b0;
        else if (in_valid && w_full)  r_overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

`ifdef DEBUG_TX_CRLF_EN
    always_ff @(posedge clk) begin
        if (rst)           r_lf_pending <= 1'b0;
        else if (w_lf_set) r_lf_pending <= 1'b1;
        else if (w_lf_clr) r_lf_pending <= 1'b0;
    end
`endif

    // Strobe is combinational in S_IDLE so S_GAP lines up with the AVR's
    // one-cycle delay in raising tx_busy.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        new_tx_data = 1'b0;
        tx_data     = 8'h00;
`ifdef DEBUG_TX_CRLF_EN
        w_lf_set    = 1'b0;
        w_lf_clr    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    new_tx_data = 1'b1;
                    tx_data     = w_head;
                    w_pop       = 1'b1;
                    w_state_nxt = S_GAP;
`ifdef DEBUG_TX_CRLF_EN
                    w_lf_set    = (w_head == ASCII_CR);
`endif
                end
            end
            S_GAP: begin
`ifdef DEBUG_TX_CRLF_EN
                w_state_nxt = r_lf_pending ? S_LF : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
`ifdef DEBUG_TX_CRLF_EN
            S_LF: begin
                if (!tx_busy) begin
                    new_tx_data = 1'b1;
                    tx_data     = ASCII_LF;
                    w_lf_clr    = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
